// File: rtl/mf_pkg.sv
// ---------------------------------------------------------------------------
// mf_pkg
//   Shared definitions for the multi-function round-robin scheduler:
//   op encodings of the shared logic lane, scheduler FSM state encoding and
//   the golden truth table used by the built-in self-test sweep.
// ---------------------------------------------------------------------------
package mf_pkg;

  // {sel1,sel2} encodings of the shared lane
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Scheduler states: normal arbitration, draining before a sweep, sweep
  typedef enum logic [1:0] {
    ARB        = 2'd0,
    SWEEP_WAIT = 2'd1,
    SWEEP      = 2'd2
  } sched_state_t;

  // Number of self-test vectors: every combination of {a,b,sel1,sel2}
  localparam int SWEEP_LEN = 16;

  // Golden truth table, bit v = expected lane output for
  //   a = v[3], b = v[2], op = v[1:0].
  //   AND: only v=12 (a=1,b=1) gives 1
  //   OR : v=5, 9, 13 give 1
  //   XOR: v=6, 10 give 1
  //   op 11 always gives 0
  // Set bits {5,6,9,10,12,13} -> 16'h3660.
  localparam logic [15:0] GOLDEN = 16'h3660;

  // Expected single-bit lane output for sweep vector v
  function automatic logic golden_bit(input logic [3:0] v);
    return GOLDEN[v];
  endfunction

endpackage

// File: rtl/mf_logic_lane.sv
// ---------------------------------------------------------------------------
// mf_logic_lane
//   Purely combinational bitwise logic lane shared by the arbiter and the
//   self-test sweep. Op 11 is illegal and yields an all-zero result.
// Ports
//   a   in  W  operand a
//   b   in  W  operand b
//   op  in  2  {sel1,sel2}: 00=a&b 01=a|b 10=a^b 11=illegal (y=0)
//   y   out W  result
// ---------------------------------------------------------------------------
module mf_logic_lane
  import mf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mf_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mf_rr_scheduler
//   Shares one bitwise logic lane between NREQ requesters with round-robin
//   arbitration and a single registered result slot (1-cycle latency,
//   1 result per cycle). A built-in sweep drives all 16 {a,b,sel1,sel2}
//   vectors through the same lane and compares against a golden table.
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   req_valid    in   NREQ    per-requester request valid
//   req_ready    out  NREQ    per-requester accept (one-hot or zero)
//   req_a        in   NREQ*W  operand a, requester i at [i*W +: W]
//   req_b        in   NREQ*W  operand b, same packing
//   req_op       in   NREQ*2  op per requester at [i*2 +: 2]
//   rsp_valid    out  1       result slot holds a valid result
//   rsp_ready    in   1       consumer accepts the result
//   rsp_data     out  W       result data
//   rsp_id       out  IDW     requester that produced rsp_data
//   rsp_err      out  1       request used illegal op 11 (data is zero)
//   sweep_start  in   1       pulse requesting a self-test sweep
//   sweep_done   out  1       one-cycle pulse at sweep completion
//   sweep_fail   out  1       sticky mismatch flag, cleared on accepted start
//   busy         out  1       sweep pending or running
// ---------------------------------------------------------------------------
module mf_rr_scheduler
  import mf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  input  logic              sweep_start,
  output logic              sweep_done,
  output logic              sweep_fail,
  output logic              busy
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  sched_state_t   state_reg, state_next;
  logic [IDW-1:0] rr_ptr_reg;
  logic [3:0]     vec_reg;
  logic           rsp_valid_reg;
  logic [W-1:0]   rsp_data_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic           rsp_err_reg;
  logic           sweep_done_reg;
  logic           sweep_fail_reg;

  // -------------------------------------------------------------------------
  // Unpack the flat request buses
  // -------------------------------------------------------------------------
  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [1:0]   op_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a[gi*W +: W];
    assign b_arr[gi]  = req_b[gi*W +: W];
    assign op_arr[gi] = req_op[gi*2 +: 2];
  end

  // -------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr. The loop runs from the farthest
  // candidate back to rr_ptr so that the nearest valid requester is the
  // last one written and therefore wins.
  // -------------------------------------------------------------------------
  logic [IDW:0]   cand;
  logic [IDW-1:0] grant_id;
  logic           grant_any;

  always_comb begin
    cand      = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (req_valid[cand[IDW-1:0]]) begin
        grant_id  = cand[IDW-1:0];
        grant_any = 1'b1;
      end
    end
  end

  // The slot can take a new result if it is empty or being popped this cycle
  logic can_load;
  logic load;

  assign can_load = !rsp_valid_reg || rsp_ready;
  assign load     = (state_reg == ARB) && grant_any && can_load;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = load && (grant_id == IDW'(gi));
  end

  // -------------------------------------------------------------------------
  // Shared lane: sweep vector replaces the granted request while sweeping
  // -------------------------------------------------------------------------
  logic [W-1:0] lane_a;
  logic [W-1:0] lane_b;
  logic [1:0]   lane_op;
  logic [W-1:0] lane_y;

  always_comb begin
    lane_a  = a_arr[grant_id];
    lane_b  = b_arr[grant_id];
    lane_op = op_arr[grant_id];
    if (state_reg == SWEEP) begin
      lane_a  = {W{vec_reg[3]}};
      lane_b  = {W{vec_reg[2]}};
      lane_op = vec_reg[1:0];
    end
  end

  mf_logic_lane #(
    .W (W)
  ) u_lane (
    .a  (lane_a),
    .b  (lane_b),
    .op (lane_op),
    .y  (lane_y)
  );

  // Only the two edge bits are checked; the lane is bitwise so any stuck
  // or mis-decoded op shows up there.
  logic gold;
  logic lane_mismatch;

  assign gold          = golden_bit(vec_reg);
  assign lane_mismatch = (lane_y[0] != gold) || (lane_y[W-1] != gold);

  // -------------------------------------------------------------------------
  // Sweep FSM
  // -------------------------------------------------------------------------
  logic sweep_accept;
  logic sweep_last;

  // A start pulse is only honoured in ARB; any grant in the same cycle
  // still completes because req_ready is evaluated from the current state.
  assign sweep_accept = (state_reg == ARB) && sweep_start;
  assign sweep_last   = (state_reg == SWEEP) && (vec_reg == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ARB;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB: begin
        if (sweep_accept) begin
          state_next = SWEEP_WAIT;
        end
      end
      SWEEP_WAIT: begin
        // The held result must drain first; no new loads occur here
        if (!rsp_valid_reg) begin
          state_next = SWEEP;
        end
      end
      SWEEP: begin
        if (sweep_last) begin
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // -------------------------------------------------------------------------
  // Result slot, round-robin pointer and sweep bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      vec_reg        <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= '0;
      rsp_err_reg    <= 1'b0;
      sweep_done_reg <= 1'b0;
      sweep_fail_reg <= 1'b0;
    end else begin
      if (load) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= lane_y;
        rsp_id_reg    <= grant_id;
        rsp_err_reg   <= (lane_op == OP_ILL);
        rr_ptr_reg    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end else if (rsp_valid_reg && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end

      // Counter wraps 15 -> 0 on the last vector, so it is ready for the
      // next sweep without an explicit clear.
      if (state_reg == SWEEP) begin
        vec_reg <= vec_reg + 4'd1;
      end else begin
        vec_reg <= '0;
      end

      sweep_done_reg <= sweep_last;

      if (sweep_accept) begin
        sweep_fail_reg <= 1'b0;
      end else if ((state_reg == SWEEP) && lane_mismatch) begin
        sweep_fail_reg <= 1'b1;
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_err    = rsp_err_reg;
  assign sweep_done = sweep_done_reg;
  assign sweep_fail = sweep_fail_reg;
  assign busy       = (state_reg != ARB);

endmodule

// File: tb/tb_mf_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mf_rr_scheduler
//   Directed bench for mf_rr_scheduler. Stimulus pushes expected responses
//   into a queue; a monitor pops and compares on every rsp handshake.
// ---------------------------------------------------------------------------
module tb_mf_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              sweep_start;
  logic              sweep_done;
  logic              sweep_fail;
  logic              busy;

  mf_rr_scheduler #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .sweep_start (sweep_start),
    .sweep_done  (sweep_done),
    .sweep_fail  (sweep_fail),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [IDW-1:0] id;
    logic           err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic expect_rsp(input logic [W-1:0] d, input int id, input logic e);
    rsp_t r;
    r.data = d;
    r.id   = IDW'(id);
    r.err  = e;
    exp_q.push_back(r);
  endtask

  // Monitor: compares every accepted response against the scoreboard
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: actual id=%0d data=0x%02h err=%0b required none",
                 rsp_id, rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] rsp id=%0d data=0x%02h err=%0b (exp id=%0d data=0x%02h err=%0b)",
                 rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_id",   32'(rsp_id),   32'(e.id));
        check("rsp_err",  32'(rsp_err),  32'(e.err));
      end
    end
  end

  // Pulses sweep_start for one cycle, then runs until sweep_done or a bound.
  task automatic run_sweep(input int pop_at, input int req_upto, input int restart_at,
                           output int done_at, output int busy_cnt,
                           output logic fail_at_done, output logic fail_first);
    done_at      = 0;
    busy_cnt     = 0;
    fail_at_done = 1'b0;
    fail_first   = 1'b0;
    sweep_start  = 1'b1;
    @(negedge clk);
    cyc();
    sweep_start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      rsp_ready   = (n == pop_at);
      req_valid   = (n <= req_upto) ? 4'b1111 : 4'b0000;
      sweep_start = (n == restart_at);
      @(negedge clk);
      if (n == 1) fail_first = sweep_fail;
      if (busy) begin
        busy_cnt++;
        check("sweep_req_ready_forced", 32'(req_ready), 32'h0);
      end
      if (sweep_done) begin
        done_at      = n;
        fail_at_done = sweep_fail;
      end
      cyc();
      if (done_at != 0) break;
    end
    sweep_start = 1'b0;
    req_valid   = '0;
    rsp_ready   = 1'b0;
  endtask

  logic [W-1:0] t2_data [4];
  int           done_at, busy_cnt, seen;
  logic         fail_at_done, fail_first;

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    req_op      = '0;
    rsp_ready   = 1'b0;
    sweep_start = 1'b0;
    t2_data[0]  = 8'h10;
    t2_data[1]  = 8'h36;
    t2_data[2]  = 8'h26;
    t2_data[3]  = 8'hDB;

    // ---------------- Reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid",  32'(rsp_valid),  32'h0);
    check("reset_req_ready",  32'(req_ready),  32'h0);
    check("reset_busy",       32'(busy),       32'h0);
    check("reset_sweep_done", 32'(sweep_done), 32'h0);
    check("reset_sweep_fail", 32'(sweep_fail), 32'h0);
    check("reset_rsp_data",   32'(rsp_data),   32'h0);
    check("reset_rsp_id",     32'(rsp_id),     32'h0);
    check("reset_rsp_err",    32'(rsp_err),    32'h0);
    cyc();
    rst = 1'b0;

    // ---------------- 1: single request ----------------
    rsp_ready = 1'b1;
    set_req(0, 8'hF0, 8'h3C, 2'b01);
    req_valid = 4'b0001;
    expect_rsp(8'hFC, 0, 1'b0);
    @(negedge clk);
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_rsp_valid_before", 32'(rsp_valid), 32'h0);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    cyc();
    @(negedge clk);
    check("t1_drained", 32'(rsp_valid), 32'h0);
    cyc();

    // ---------------- rr_ptr wrap 3 -> 0 ----------------
    set_req(3, 8'h0F, 8'hF0, 2'b00);
    req_valid = 4'b1000;
    expect_rsp(8'h00, 3, 1'b0);
    @(negedge clk);
    check("wrap_req_ready", 32'(req_ready), 32'h8);
    cyc();

    // ---------------- 2: all requesters, full throughput ----------------
    set_req(0, 8'h12, 8'h34, 2'b00);
    set_req(1, 8'h12, 8'h34, 2'b01);
    set_req(2, 8'h12, 8'h34, 2'b10);
    set_req(3, 8'hC3, 8'h5A, 2'b01);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_rsp(t2_data[k % 4], k % 4, 1'b0);
      @(negedge clk);
      check("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    cyc();

    // ---------------- 3: backpressure ----------------
    rsp_ready = 1'b0;
    set_req(1, 8'hAA, 8'h55, 2'b10);
    req_valid = 4'b0010;
    expect_rsp(8'hFF, 1, 1'b0);
    @(negedge clk);
    check("t3_first_grant", 32'(req_ready), 32'h2);
    cyc();
    set_req(1, 8'h0F, 8'h33, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_req_ready", 32'(req_ready), 32'h0);
      check("t3_hold_valid",     32'(rsp_valid), 32'h1);
      check("t3_hold_data",      32'(rsp_data),  32'hFF);
      check("t3_hold_id",        32'(rsp_id),    32'h1);
      cyc();
    end
    rsp_ready = 1'b1;
    expect_rsp(8'h03, 1, 1'b0);
    @(negedge clk);
    check("t3_pop_and_grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("t3_reload_valid", 32'(rsp_valid), 32'h1);
    cyc();

    // ---------------- 4: illegal op ----------------
    set_req(2, 8'hFF, 8'hFF, 2'b11);
    req_valid = 4'b0100;
    expect_rsp(8'h00, 2, 1'b1);
    @(negedge clk);
    check("t4_req_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    @(negedge clk);
    cyc();

    // ---------------- 5: sweep with a held result ----------------
    rsp_ready = 1'b0;
    set_req(0, 8'h81, 8'h18, 2'b10);
    req_valid = 4'b0001;
    expect_rsp(8'h99, 0, 1'b0);
    @(negedge clk);
    check("t5_grant_wraps_to_0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("t5_held_valid", 32'(rsp_valid), 32'h1);
    check("t5_idle_busy",  32'(busy),      32'h0);
    cyc();
    // 3 drain cycles (pop in the 3rd), 1 cycle to see empty, 16 vectors
    run_sweep(3, 3, 0, done_at, busy_cnt, fail_at_done, fail_first);
    check("t5_done_cycle", 32'(done_at),      32'd21);
    check("t5_busy_count", 32'(busy_cnt),     32'd20);
    check("t5_sweep_fail", 32'(fail_at_done), 32'h0);
    @(negedge clk);
    check("t5_done_one_cycle", 32'(sweep_done), 32'h0);
    check("t5_busy_after",     32'(busy),       32'h0);
    cyc();

    // Broken lane: every vector whose golden bit is 1 must mismatch
    force dut.lane_y = '0;
    run_sweep(0, 0, 0, done_at, busy_cnt, fail_at_done, fail_first);
    release dut.lane_y;
    check("t5f_done_cycle", 32'(done_at),      32'd18);
    check("t5f_busy_count", 32'(busy_cnt),     32'd17);
    check("t5f_sweep_fail", 32'(fail_at_done), 32'h1);
    @(negedge clk);
    check("t5f_fail_sticky", 32'(sweep_fail), 32'h1);
    cyc();

    // Clean sweep clears the flag at start; a start while busy is ignored
    run_sweep(0, 0, 5, done_at, busy_cnt, fail_at_done, fail_first);
    check("t5c_fail_cleared", 32'(fail_first),   32'h0);
    check("t5c_done_cycle",   32'(done_at),      32'd18);
    check("t5c_sweep_fail",   32'(fail_at_done), 32'h0);
    @(negedge clk);
    check("t5c_restart_ignored", 32'(busy), 32'h0);
    cyc();

    // ---------------- 6: reset mid-sweep at v=7 ----------------
    sweep_start = 1'b1;
    @(negedge clk);
    cyc();
    sweep_start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      cyc();
    end
    @(negedge clk);
    check("t6_busy_before_reset", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_busy_reset",       32'(busy),       32'h0);
    check("t6_rsp_valid_reset",  32'(rsp_valid),  32'h0);
    check("t6_sweep_done_reset", 32'(sweep_done), 32'h0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sweep_done || busy) seen++;
      cyc();
    end
    check("t6_no_sweep_after_reset", 32'(seen), 32'h0);

    set_req(0, 8'h5A, 8'h0F, 2'b01);
    set_req(1, 8'h11, 8'h22, 2'b01);
    set_req(2, 8'h11, 8'h22, 2'b10);
    set_req(3, 8'h11, 8'h22, 2'b00);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t6_grant_req0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("t6_held_valid", 32'(rsp_valid), 32'h1);
    check("t6_held_data",  32'(rsp_data),  32'h5F);
    check("t6_held_id",    32'(rsp_id),    32'h0);
    // Reset while a result is held drops it
    rst = 1'b1;
    #1;
    check("t6_drop_held", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_still_empty", 32'(rsp_valid), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
